// File: rtl/sched_pkg.sv
// rtl/sched_pkg.sv - shared types and defaults for the quantum scheduler
// Purpose: scheduler state encoding and default sizing constants.
// Ports: none (package).
package sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_LOAD,
    ST_RUN,
    ST_SAVE
  } state_t;

  localparam int SCHED_N_PROG          = 8;
  localparam int SCHED_PID_W           = 3;
  localparam int SCHED_QW              = 16;
  localparam int SCHED_DEFAULT_QUANTUM = 100;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - round-robin next-slot picker
// Purpose: find the first active slot after cur_pid, wrapping modulo N_PROG.
// Ports:
//   active_mask in  N_PROG  active slot bitmap
//   cur_pid     in  PID_W   current program id (search starts at cur_pid+1)
//   next_pid    out PID_W   winning slot
//   found       out 1       any slot active
module rr_pick
  import sched_pkg::*;
#(
  parameter int N_PROG = SCHED_N_PROG,
  parameter int PID_W  = SCHED_PID_W
) (
  input  logic [N_PROG-1:0] active_mask,
  input  logic [PID_W-1:0]  cur_pid,
  output logic [PID_W-1:0]  next_pid,
  output logic              found
);

  logic [2*N_PROG-1:0] doubled;
  logic [N_PROG-1:0]   rotated;
  int                  start_i;
  int                  pick_i;

  // Rotate so the slot after cur_pid lands at bit 0, then take the lowest
  // set bit; the rotation offset is added back to get an absolute slot.
  always_comb begin
    start_i  = (int'(cur_pid) + 1) % N_PROG;
    doubled  = {active_mask, active_mask};
    rotated  = doubled[start_i +: N_PROG];
    found    = 1'b0;
    pick_i   = 0;
    for (int k = N_PROG - 1; k >= 0; k--) begin
      if (rotated[k]) begin
        found  = 1'b1;
        pick_i = (start_i + k) % N_PROG;
      end
    end
    next_pid = PID_W'(pick_i);
  end

endmodule

// File: rtl/quantum_scheduler.sv
// rtl/quantum_scheduler.sv - preemptive round-robin program scheduler
// Purpose: counts retired instructions against a quantum, sequences context
// save/load with the data RAM, and selects the next active program.
// Optional feature macro: SCHED_STATS_EN (adds preempt_count/switch_count).
// Ports:
//   clock, reset        clock; asynchronous active-low reset
//   instr_retire        pulse per retired instruction
//   def_quantum         pulse; load quantum_in (0 stored as 1)
//   start_program       pulse; activate slot start_pid
//   end_program         pulse; running program ended
//   ctx_done            level; context save/load complete
//   save_ctx, load_ctx  context handshake requests
//   change_program      pulse when cur_pid changes
//   cur_pid, running, idle, active_mask  status
//   preempt_count, switch_count  (SCHED_STATS_EN only) saturating counters
module quantum_scheduler
  import sched_pkg::*;
#(
  parameter int N_PROG          = SCHED_N_PROG,
  parameter int PID_W           = SCHED_PID_W,
  parameter int QW              = SCHED_QW,
  parameter int DEFAULT_QUANTUM = SCHED_DEFAULT_QUANTUM
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              instr_retire,
  input  logic              def_quantum,
  input  logic [QW-1:0]     quantum_in,
  input  logic              start_program,
  input  logic [PID_W-1:0]  start_pid,
  input  logic              end_program,
  input  logic              ctx_done,
  output logic              save_ctx,
  output logic              load_ctx,
  output logic              change_program,
  output logic [PID_W-1:0]  cur_pid,
  output logic              running,
  output logic              idle,
  output logic [N_PROG-1:0] active_mask
`ifdef SCHED_STATS_EN
  ,
  output logic [15:0]       preempt_count,
  output logic [15:0]       switch_count
`endif
);

  state_t            state;
  logic [QW-1:0]     quantum_reg;
  logic [QW-1:0]     count;
  logic [N_PROG-1:0] mask_next;
  logic [PID_W-1:0]  next_pid;
  logic              found;
  logic              expire;

  rr_pick #(.N_PROG(N_PROG), .PID_W(PID_W)) u_rr_pick (
    .active_mask (active_mask),
    .cur_pid     (cur_pid),
    .next_pid    (next_pid),
    .found       (found)
  );

  // Clear is applied after set so an end of the running program beats a
  // simultaneous restart of the same slot.
  always_comb begin
    mask_next = active_mask;
    if (start_program) mask_next[start_pid] = 1'b1;
    if (state == ST_RUN && end_program) mask_next[cur_pid] = 1'b0;
  end

  // >= rather than == so a quantum shrunk below the current count still
  // expires on the very next retire.
  assign expire = (count >= quantum_reg - QW'(1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= ST_IDLE;
      cur_pid        <= '0;
      active_mask    <= '0;
      quantum_reg    <= QW'(DEFAULT_QUANTUM);
      count          <= '0;
      save_ctx       <= 1'b0;
      load_ctx       <= 1'b0;
      change_program <= 1'b0;
      running        <= 1'b0;
      idle           <= 1'b1;
`ifdef SCHED_STATS_EN
      preempt_count  <= '0;
      switch_count   <= '0;
`endif
    end else begin
      change_program <= 1'b0;
      active_mask    <= mask_next;
      if (def_quantum) quantum_reg <= (quantum_in == '0) ? QW'(1) : quantum_in;

      case (state)
        ST_IDLE: begin
          if (active_mask != '0) begin
            state <= ST_SELECT;
            idle  <= 1'b0;
          end
        end
        ST_SELECT: begin
          if (found) begin
            cur_pid  <= next_pid;
            load_ctx <= 1'b1;
            state    <= ST_LOAD;
            if (next_pid != cur_pid) begin
              change_program <= 1'b1;
`ifdef SCHED_STATS_EN
              if (switch_count != 16'hFFFF) switch_count <= switch_count + 16'd1;
`endif
            end
          end else begin
            state <= ST_IDLE;
            idle  <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (ctx_done) begin
            load_ctx <= 1'b0;
            running  <= 1'b1;
            count    <= '0;
            state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (end_program) begin
            running <= 1'b0;
            state   <= ST_SELECT;
          end else if (instr_retire) begin
            if (count != '1) count <= count + QW'(1);
            if (expire) begin
              running  <= 1'b0;
              save_ctx <= 1'b1;
              state    <= ST_SAVE;
`ifdef SCHED_STATS_EN
              if (preempt_count != 16'hFFFF) preempt_count <= preempt_count + 16'd1;
`endif
            end
          end
        end
        ST_SAVE: begin
          if (ctx_done) begin
            save_ctx <= 1'b0;
            state    <= ST_SELECT;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_quantum_scheduler.sv
// tb/tb_quantum_scheduler.sv - directed self-checking bench for quantum_scheduler
module tb_quantum_scheduler;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        instr_retire = 1'b0;
  logic        def_quantum = 1'b0;
  logic [15:0] quantum_in = '0;
  logic        start_program = 1'b0;
  logic [2:0]  start_pid = '0;
  logic        end_program = 1'b0;
  logic        ctx_done = 1'b0;
  logic        save_ctx, load_ctx, change_program, running, idle;
  logic [2:0]  cur_pid;
  logic [7:0]  active_mask;
`ifdef SCHED_STATS_EN
  logic [15:0] preempt_count, switch_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  quantum_scheduler dut (
    .clock          (clock),
    .reset          (reset),
    .instr_retire   (instr_retire),
    .def_quantum    (def_quantum),
    .quantum_in     (quantum_in),
    .start_program  (start_program),
    .start_pid      (start_pid),
    .end_program    (end_program),
    .ctx_done       (ctx_done),
    .save_ctx       (save_ctx),
    .load_ctx       (load_ctx),
    .change_program (change_program),
    .cur_pid        (cur_pid),
    .running        (running),
    .idle           (idle),
    .active_mask    (active_mask)
`ifdef SCHED_STATS_EN
    ,
    .preempt_count  (preempt_count),
    .switch_count   (switch_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // reset state
    tick();
    tick();
    chk("rst_idle", 32'(idle), 1);
    chk("rst_running", 32'(running), 0);
    chk("rst_cur_pid", 32'(cur_pid), 0);
    chk("rst_mask", 32'(active_mask), 0);
    chk("rst_strobes", 32'({save_ctx, load_ctx, change_program}), 0);
    reset = 1'b1;
    tick();

    // start pid 2 from idle
    start_program = 1'b1; start_pid = 3'd2;
    tick();
    start_program = 1'b0;
    chk("t1_mask", 32'(active_mask), 32'h04);
    chk("t1_idle_still", 32'(idle), 1);
    tick();
    chk("t1_select_idle", 32'(idle), 0);
    tick();
    chk("t1_cur_pid", 32'(cur_pid), 2);
    chk("t1_change", 32'(change_program), 1);
    chk("t1_load", 32'(load_ctx), 1);
    tick();
    chk("t1_load_held", 32'(load_ctx), 1);
    chk("t1_change_pulse", 32'(change_program), 0);
    ctx_done = 1'b1;
    tick();
    ctx_done = 1'b0;
    chk("t1_running", 32'(running), 1);
    chk("t1_load_drop", 32'(load_ctx), 0);

    // quantum 3, pids 0 and 2 active, 2 running
    def_quantum = 1'b1; quantum_in = 16'd3;
    start_program = 1'b1; start_pid = 3'd0;
    tick();
    def_quantum = 1'b0; start_program = 1'b0;
    chk("t2_mask", 32'(active_mask), 32'h05);
    instr_retire = 1'b1;
    tick();
    tick();
    chk("t2_run_before_expiry", 32'(running), 1);
    tick();
    instr_retire = 1'b0;
    chk("t2_save", 32'(save_ctx), 1);
    chk("t2_not_running", 32'(running), 0);
    tick();
    chk("t2_save_held", 32'(save_ctx), 1);
    ctx_done = 1'b1;
    tick();
    ctx_done = 1'b0;
    chk("t2_save_drop", 32'(save_ctx), 0);
    tick();
    chk("t2_wrap_pid", 32'(cur_pid), 0);
    chk("t2_change", 32'(change_program), 1);
    chk("t2_load", 32'(load_ctx), 1);
    tick();
    ctx_done = 1'b1;
    tick();
    ctx_done = 1'b0;
    chk("t2_running", 32'(running), 1);

    // reach pid 5 alone with quantum 4
    end_program = 1'b1; start_program = 1'b1; start_pid = 3'd5;
    def_quantum = 1'b1; quantum_in = 16'd4;
    tick();
    end_program = 1'b0; start_program = 1'b0; def_quantum = 1'b0;
    chk("t3_mask", 32'(active_mask), 32'h24);
    chk("t3_end_not_running", 32'(running), 0);
    tick();
    chk("t3_pick2", 32'(cur_pid), 2);
    ctx_done = 1'b1;
    tick();
    ctx_done = 1'b0;
    end_program = 1'b1;
    tick();
    end_program = 1'b0;
    chk("t3_mask5", 32'(active_mask), 32'h20);
    tick();
    chk("t3_pick5", 32'(cur_pid), 5);
    chk("t3_change5", 32'(change_program), 1);
    ctx_done = 1'b1;
    tick();
    ctx_done = 1'b0;
    instr_retire = 1'b1;
    tick(); tick(); tick();
    chk("t3_run_after3", 32'(running), 1);
    tick();
    instr_retire = 1'b0;
    chk("t3_save", 32'(save_ctx), 1);
    ctx_done = 1'b1;
    tick();
    ctx_done = 1'b0;
    tick();
    chk("t3_reselect_pid", 32'(cur_pid), 5);
    chk("t3_no_change", 32'(change_program), 0);
    chk("t3_load_self", 32'(load_ctx), 1);
    ctx_done = 1'b1;
    tick();
    ctx_done = 1'b0;
    instr_retire = 1'b1;
    tick(); tick(); tick();
    chk("t3_count_restart", 32'(running), 1);

    // end_program coincides with the expiring retire
    end_program = 1'b1;
    tick();
    instr_retire = 1'b0; end_program = 1'b0;
    chk("t4_no_save", 32'(save_ctx), 0);
    chk("t4_mask_empty", 32'(active_mask), 0);
    chk("t4_not_running", 32'(running), 0);
    tick();
    chk("t4_idle", 32'(idle), 1);
    chk("t4_no_load", 32'(load_ctx), 0);

    // quantum 0 -> every retire preempts
    start_program = 1'b1; start_pid = 3'd1;
    tick();
    start_program = 1'b0;
    tick();
    tick();
    chk("t5_pick1", 32'(cur_pid), 1);
    ctx_done = 1'b1;
    tick();
    ctx_done = 1'b0;
    def_quantum = 1'b1; quantum_in = 16'd0;
    tick();
    def_quantum = 1'b0;
    chk("t5_running", 32'(running), 1);
    instr_retire = 1'b1;
    tick();
    instr_retire = 1'b0;
    chk("t5_q0_save", 32'(save_ctx), 1);
    ctx_done = 1'b1;
    tick();
    ctx_done = 1'b0;
    tick();
    chk("t5_no_change", 32'(change_program), 0);
    ctx_done = 1'b1;
    tick();
    ctx_done = 1'b0;

    // quantum shrunk below count
    def_quantum = 1'b1; quantum_in = 16'd100;
    tick();
    def_quantum = 1'b0;
    instr_retire = 1'b1;
    repeat (5) tick();
    instr_retire = 1'b0;
    def_quantum = 1'b1; quantum_in = 16'd2;
    tick();
    def_quantum = 1'b0;
    chk("t5_run_count5", 32'(running), 1);
    chk("t5_no_save_yet", 32'(save_ctx), 0);
    instr_retire = 1'b1;
    tick();
    instr_retire = 1'b0;
    chk("t5_shrink_save", 32'(save_ctx), 1);

`ifdef SCHED_STATS_EN
    chk("t6_preempts", 32'(preempt_count), 4);
    chk("t6_switches", 32'(switch_count), 5);
`endif

    // asynchronous reset during save
    reset = 1'b0;
    #1;
    chk("t6_save_clr", 32'(save_ctx), 0);
    chk("t6_idle", 32'(idle), 1);
    chk("t6_mask", 32'(active_mask), 0);
    chk("t6_cur_pid", 32'(cur_pid), 0);
    chk("t6_running", 32'(running), 0);
`ifdef SCHED_STATS_EN
    chk("t6_preempt_clr", 32'(preempt_count), 0);
    chk("t6_switch_clr", 32'(switch_count), 0);
`endif
    tick();
    reset = 1'b1;
    tick();
    chk("t6_stay_idle", 32'(idle), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
